// File: rtl/relu_maxpool2d_stream.sv
// relu_maxpool2d_stream
//   Streaming ReLU followed by non-overlapping 2x2 max pooling with stride 2.
//   The block takes one feature-map stage's raster-order float32 stream and
//   produces one pooled value per 2x2 window, also in raster order.
//   There is no backpressure. Every cycle with valid_in=1 consumes a pixel.
//   Idle cycles freeze all state.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   valid_in   in   data_in carries a pixel this cycle
//   data_in    in   float32 conv+bias result
//   valid_out  out  one-cycle pulse: data_out holds a pooled value
//   data_out   out  pooled float32, always >= +0
//   frame_done out  pulses together with the last pooled value of a frame
module relu_maxpool2d_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_done
);

  localparam int COL_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
  localparam int LB_W  = (WIDTH > 2) ? $clog2(WIDTH / 2) : 1;

  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  validOut_q, validOut_d;
  logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
  logic                  frameDone_q, frameDone_d;

  // Holds the horizontal max of every window's top row until the odd row arrives.
  logic [DATA_WIDTH-1:0] lbuf [WIDTH/2];

  logic [DATA_WIDTH-1:0] reluX;
  logic [DATA_WIDTH-1:0] hmax;
  logic [DATA_WIDTH-1:0] lbufRd;
  logic [DATA_WIDTH-1:0] vmax;
  logic [LB_W-1:0]       lbIdx;
  logic                  lastCol;
  logic                  lastRow;
  logic                  outFire;
  logic                  lbWrite;

  // Any value with the sign bit set becomes +0. That covers -0 and negative NaN.
  // Once ReLU has run the sign is always 0, so the float max reduces to an unsigned
  // compare of the remaining bits. Positive Inf and NaN therefore win.
  always_comb begin
    reluX  = data_in[DATA_WIDTH-1] ? '0 : data_in;
    hmax   = (hold_q[DATA_WIDTH-2:0] >= reluX[DATA_WIDTH-2:0]) ? hold_q : reluX;
    lbIdx  = LB_W'(col_q >> 1);
    lbufRd = lbuf[lbIdx];
    vmax   = (lbufRd[DATA_WIDTH-2:0] >= hmax[DATA_WIDTH-2:0]) ? lbufRd : hmax;
  end

  // A window completes on the odd column of an odd row.
  // The top half of each window is stashed on the odd column of an even row.
  always_comb begin
    lastCol = (col_q == COL_W'(WIDTH - 1));
    lastRow = (row_q == ROW_W'(HEIGHT - 1));
    outFire = valid_in && row_q[0] && col_q[0];
    lbWrite = valid_in && !row_q[0] && col_q[0];
  end

  // Next-state logic for the raster counters, the horizontal hold register and
  // the registered outputs. data_out keeps its last value between pulses.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    validOut_d  = outFire;
    dataOut_d   = outFire ? vmax : dataOut_q;
    frameDone_d = outFire && lastRow && lastCol;
    if (valid_in) begin
      if (!col_q[0]) begin
        hold_d = reluX;
      end
      if (lastCol) begin
        col_d = '0;
        row_d = lastRow ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Reset discards any partial frame and any pending output pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      validOut_q  <= 1'b0;
      dataOut_q   <= '0;
      frameDone_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      validOut_q  <= validOut_d;
      dataOut_q   <= dataOut_d;
      frameDone_q <= frameDone_d;
    end
  end

  // The line buffer needs no reset. Each entry is written on an even row
  // before it is read on the following odd row.
  always_ff @(posedge clk) begin
    if (lbWrite) begin
      lbuf[lbIdx] <= hmax;
    end
  end

  assign valid_out  = validOut_q;
  assign data_out   = dataOut_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_relu_maxpool2d_stream.sv
// Testbench for relu_maxpool2d_stream. A 4x4 instance covers the scenario tests.
// A default-size 56x56 instance is checked against a reference model.
module tb_relu_maxpool2d_stream;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int BW = 56;
  localparam int BH = 56;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] data_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic        frame_done;

  logic        bValid;
  logic [31:0] bData;
  logic        bValidOut;
  logic [31:0] bDataOut;
  logic        bFrameDone;

  int testsRun    = 0;
  int testsFailed = 0;

  // Scoreboards hold {frame_done, data} entries in the order they are expected.
  logic [32:0] expQ[$];
  logic [32:0] bigQ[$];
  int outCount    = 0;
  int fdCount     = 0;
  int bigOutCount = 0;
  int bigFdCount  = 0;

  // tbOddOdd marks a driven pixel that completes a window. expValid is the
  // valid_out level required one cycle after that pixel is accepted.
  logic tbOddOdd = 1'b0;
  logic expValid = 1'b0;

  logic [31:0] frameA   [H][W];
  logic [31:0] bigFrame [BH][BW];

  relu_maxpool2d_stream #(.DATA_WIDTH(32), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .valid_out(valid_out), .data_out(data_out), .frame_done(frame_done)
  );

  relu_maxpool2d_stream #(.DATA_WIDTH(32), .WIDTH(BW), .HEIGHT(BH)) dutBig (
    .clk(clk), .rst(rst), .valid_in(bValid), .data_in(bData),
    .valid_out(bValidOut), .data_out(bDataOut), .frame_done(bFrameDone)
  );

  always #5 clk = ~clk;

  // Reference behaviour: ReLU, then max of non-negative floats as an unsigned compare.
  function automatic logic [31:0] relu(input logic [31:0] x);
    return x[31] ? 32'h0 : x;
  endfunction

  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    return (a[30:0] >= b[30:0]) ? a : b;
  endfunction

  function automatic void pushExpected();
    logic [31:0] m;
    for (int wr = 0; wr < H/2; wr++) begin
      for (int wc = 0; wc < W/2; wc++) begin
        m = fmax(fmax(relu(frameA[2*wr][2*wc]), relu(frameA[2*wr][2*wc+1])),
                 fmax(relu(frameA[2*wr+1][2*wc]), relu(frameA[2*wr+1][2*wc+1])));
        expQ.push_back({(wr == H/2-1) && (wc == W/2-1), m});
      end
    end
  endfunction

  always @(posedge clk) expValid <= tbOddOdd;

  // Scoreboard consumer for the small instance.
  always @(negedge clk) begin : monSmall
    logic [32:0] e;
    if (rst === 1'b1) begin
      testsRun++;
      if (valid_out !== expValid) begin
        testsFailed++;
        $display("[TB] FAIL latency: valid_out=%b required %b at %0t", valid_out, expValid, $time);
      end
      if (valid_out === 1'b1) begin
        outCount++;
        if (frame_done === 1'b1) fdCount++;
        testsRun++;
        if (expQ.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL unexpected_output: got %h, required no output", data_out);
        end else begin
          e = expQ.pop_front();
          if ({frame_done, data_out} !== e) begin
            testsFailed++;
            $display("[TB] FAIL pooled_value: got fd=%b data=%h, required fd=%b data=%h",
                     frame_done, data_out, e[32], e[31:0]);
          end
        end
      end else begin
        testsRun++;
        if (frame_done !== 1'b0) begin
          testsFailed++;
          $display("[TB] FAIL stray_frame_done: got %b, required 0", frame_done);
        end
      end
    end
  end

  // Scoreboard consumer for the default-size instance.
  always @(negedge clk) begin : monBig
    logic [32:0] e;
    if (rst === 1'b1 && bValidOut === 1'b1) begin
      bigOutCount++;
      if (bFrameDone === 1'b1) bigFdCount++;
      testsRun++;
      if (bigQ.size() == 0) begin
        testsFailed++;
        $display("[TB] FAIL big_unexpected_output: got %h, required no output", bDataOut);
      end else begin
        e = bigQ.pop_front();
        if ({bFrameDone, bDataOut} !== e) begin
          testsFailed++;
          $display("[TB] FAIL big_pooled_value: got fd=%b data=%h, required fd=%b data=%h",
                   bFrameDone, bDataOut, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic oddOdd);
    @(negedge clk);
    valid_in = v;
    data_in  = d;
    tbOddOdd = v & oddOdd;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 32'h0, 1'b0);
  endtask

  task automatic sendFrame(input int gapMax);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gapMax > 0) begin
          repeat ($urandom_range(0, gapMax)) applyStimulus(1'b0, $urandom, 1'b0);
        end
        applyStimulus(1'b1, frameA[r][c], (r % 2 == 1) && (c % 2 == 1));
      end
    end
  endtask

  task automatic loadBasic();
    logic [31:0] rows [4][4];
    rows[0] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000000};
    rows[1] = '{32'h3F000000, 32'h3F000000, 32'h40000000, 32'h3F800000};
    rows[2] = '{32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000};
    rows[3] = '{32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000};
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        frameA[r][c] = rows[r][c];
  endtask

  task automatic checkCounts(input string name, input int o0, input int f0,
                             input int nOut, input int nFd);
    testsRun++;
    if (outCount - o0 != nOut) begin
      testsFailed++;
      $display("[TB] FAIL %s_count: got %0d outputs, required %0d", name, outCount - o0, nOut);
    end
    testsRun++;
    if (fdCount - f0 != nFd) begin
      testsFailed++;
      $display("[TB] FAIL %s_frame_done: got %0d pulses, required %0d", name, fdCount - f0, nFd);
    end
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL %s_leftover: got %0d pending, required 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; valid_in = 1'b0; data_in = '0; bValid = 1'b0; bData = '0;
    #2;
    testsRun++;
    if ({valid_out, data_out, frame_done} !== 34'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: got v=%b d=%h fd=%b, required 0/0/0", valid_out, data_out, frame_done);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_basic();
    int o0 = outCount, f0 = fdCount;
    loadBasic();
    pushExpected();
    sendFrame(0);
    idle(3);
    checkCounts("basic", o0, f0, 4, 1);
  endtask

  // Window 0 all negative gives 0. Window 1 gives 0.5. Window 2 mixes -NaN with
  // +Inf and gives +Inf. Window 3 carries a positive NaN that must propagate.
  task automatic test_relu();
    int o0 = outCount, f0 = fdCount;
    frameA[0] = '{32'hC0400000, 32'h80000000, 32'hC0400000, 32'h3F000000};
    frameA[1] = '{32'hBF800000, 32'hC0000000, 32'hBF800000, 32'hC0000000};
    frameA[2] = '{32'hFFC00000, 32'h3F800000, 32'h7FC00000, 32'h40000000};
    frameA[3] = '{32'h7F800000, 32'h40000000, 32'h3F800000, 32'hFF800000};
    pushExpected();
    sendFrame(0);
    idle(3);
    checkCounts("relu", o0, f0, 4, 1);
  endtask

  task automatic test_gapped();
    int o0 = outCount, f0 = fdCount;
    loadBasic();
    pushExpected();
    sendFrame(2);
    idle(3);
    checkCounts("gapped", o0, f0, 4, 1);
  endtask

  task automatic test_back_to_back();
    int o0 = outCount, f0 = fdCount;
    loadBasic();
    pushExpected();
    sendFrame(0);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        frameA[r][c] = (r == 3 && c == 0) ? 32'h41200000 : 32'hBF800000;
    pushExpected();
    sendFrame(0);
    idle(3);
    checkCounts("back_to_back", o0, f0, 8, 2);
  endtask

  task automatic test_reset_mid_frame();
    int o0, f0;
    loadBasic();
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, frameA[i / W][i % W], (i == 5));
    @(posedge clk);
    #1;
    testsRun++;
    if (valid_out !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL pending_output: got valid_out=%b, required 1", valid_out);
    end
    rst = 1'b0; valid_in = 1'b0; tbOddOdd = 1'b0;
    #1;
    testsRun++;
    if ({valid_out, data_out, frame_done} !== 34'h0) begin
      testsFailed++;
      $display("[TB] FAIL async_reset: got v=%b d=%h fd=%b, required 0/0/0", valid_out, data_out, frame_done);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    o0 = outCount; f0 = fdCount;
    pushExpected();
    sendFrame(0);
    idle(3);
    checkCounts("reset_mid_frame", o0, f0, 4, 1);
  endtask

  task automatic test_default_size();
    int o0 = bigOutCount, f0 = bigFdCount;
    logic [31:0] m;
    for (int r = 0; r < BH; r++)
      for (int c = 0; c < BW; c++)
        bigFrame[r][c] = $urandom;
    for (int wr = 0; wr < BH/2; wr++)
      for (int wc = 0; wc < BW/2; wc++) begin
        m = fmax(fmax(relu(bigFrame[2*wr][2*wc]), relu(bigFrame[2*wr][2*wc+1])),
                 fmax(relu(bigFrame[2*wr+1][2*wc]), relu(bigFrame[2*wr+1][2*wc+1])));
        bigQ.push_back({(wr == BH/2-1) && (wc == BW/2-1), m});
      end
    for (int r = 0; r < BH; r++)
      for (int c = 0; c < BW; c++) begin
        @(negedge clk);
        bValid = 1'b1;
        bData  = bigFrame[r][c];
      end
    @(negedge clk);
    bValid = 1'b0;
    repeat (3) @(negedge clk);
    testsRun++;
    if (bigOutCount - o0 != 784) begin
      testsFailed++;
      $display("[TB] FAIL default_count: got %0d outputs, required 784", bigOutCount - o0);
    end
    testsRun++;
    if (bigFdCount - f0 != 1) begin
      testsFailed++;
      $display("[TB] FAIL default_frame_done: got %0d pulses, required 1", bigFdCount - f0);
    end
    testsRun++;
    if (bigQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL default_leftover: got %0d pending, required 0", bigQ.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_gapped();
    test_back_to_back();
    test_reset_mid_frame();
    test_default_size();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/relu_maxpool2d_stream.md
Name: relu_maxpool2d_stream

Overview:
- Consumes the raster-order IEEE-754 single-precision stream produced by one per-filter feature-map stage (its valid_out/data_out pair).
- Applies ReLU and then non-overlapping 2x2 max pooling, stride 2.
- Emits one pooled value per 2x2 window in raster order. Output feeds the next layer's input FIFO.
- One instance per filter.

Parameters:
- DATA_WIDTH, 32, word width; float32 only.
- WIDTH, 56, pixels per input row; must be even.
- HEIGHT, 56, rows per input frame; must be even.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- valid_in  input  1  data_in is a valid pixel this cycle.
- data_in  input  DATA_WIDTH  conv+bias result, float32.
- valid_out  output  1  one-cycle pulse; data_out holds a pooled value.
- data_out  output  DATA_WIDTH  pooled float32, always >= +0.
- frame_done  output  1  one-cycle pulse together with the last pooled value of a frame.

Behaviour:
- Reset (rst=0, async):
  - valid_out=0, data_out=0, frame_done=0.
  - col=0, row=0, hold register=0.
  - Line-buffer contents are don't-care: every entry is written on an even row before it is read on the following odd row.
- No backpressure. A pixel is consumed on every cycle with valid_in=1. Gaps (valid_in=0) are allowed anywhere and freeze all state. The downstream FIFO must absorb every valid_out.
- ReLU:
  - If data_in[31]=1, the value becomes 0x00000000. This covers negative numbers, -0 and negative NaN.
  - Otherwise the value passes unchanged.
- Compare: after ReLU, the sign bit is always 0. max(a,b) is therefore an unsigned compare of bits [30:0]. Ties select either value (identical bits). Positive NaN/Inf compare as largest and propagate.
- Counters:
  - col runs 0..WIDTH-1 and wraps to 0, incrementing row.
  - row runs 0..HEIGHT-1 and wraps to 0.
  - Both advance only on valid_in.
- Horizontal stage:
  - Even col: hold <= relu(x).
  - Odd col: hmax = max(hold, relu(x)), combinational.
- Line buffer: WIDTH/2 entries x DATA_WIDTH, indexed by col>>1.
  - Even row, odd col: lbuf[col>>1] <= hmax. No output.
  - Odd row, odd col: data_out <= max(lbuf[col>>1], hmax) and valid_out <= 1, registered. Latency is 1 cycle after the accepting edge.
- valid_out:
  - 0 on every other cycle; data_out holds its last value.
  - Exactly WIDTH/2 pulses per odd row, (WIDTH/2)*(HEIGHT/2) per frame.
- frame_done: asserted in the same cycle as valid_out for the pixel at row=HEIGHT-1, col=WIDTH-1.
- Back-to-back frames: the next frame's first pixel may arrive on the cycle right after the last pixel. No bubble is required and counters are already at 0.
- Reset mid-frame: the partial frame is discarded and the next valid_in is treated as pixel (0,0). A pending valid_out is cleared.
- Line buffer: plain register array or inferred RAM with 1-write/1-read per cycle. The read address equals the write address slot and is never accessed the same cycle by both, since reads occur only on odd rows and writes only on even rows.

Test Plan (WIDTH=4, HEIGHT=4 unless noted):
- Basic pooling:
  - Stimulus: row0 = 1.0 (0x3F800000), 2.0 (0x40000000), 0.5 (0x3F000000), 0.5; row1 = 0.5, 0.5, 2.0, 1.0 (0x3F800000); rows 2-3 all 0.5.
  - Required: outputs 0x40000000, 0x40000000, 0x3F000000, 0x3F000000. Each valid_out comes one cycle after the odd-col pixel of an odd row. frame_done coincides with the 4th output only.
- ReLU:
  - Stimulus: a window of -3.0 (0xC0400000), -0.0 (0x80000000), -1.0, -2.0.
  - Required: output 0x00000000. A window {-3.0, 0.5, -1.0, -2.0} gives 0x3F000000.
- Gapped input:
  - Stimulus: scenario 1 with valid_in toggled 1,0,0,1,... randomly.
  - Required: identical output values and count. valid_out never asserts without a preceding accepted odd-col, odd-row pixel.
- Back-to-back frames:
  - Stimulus: two frames, 32 continuous valid cycles.
  - Required: 8 outputs, with frame_done on the 4th and 8th. The second frame's results are independent of the first.
- Reset mid-frame:
  - Stimulus: assert rst low for one cycle after 6 pixels, then send a full frame.
  - Required: valid_out/data_out go to 0 immediately (async). Exactly 4 outputs follow, matching the standalone frame.
- Default size:
  - Stimulus: WIDTH=HEIGHT=56 with random floats.
  - Required: 784 outputs that match a reference model of ReLU followed by 2x2 max pooling, and a single frame_done.
